dct_transpose_ctrl: RTL

- Sequencer for the 256x16 DCT transpose buffer between the row-pass and column-pass 1-D 8-point DCTs.
- Accepts row-pass coefficients in row-major order and writes them into one of two 64-entry ping-pong banks.
- Reads the full bank back column-major, producing the transposed 8x8 block on a valid/ready stream with backpressure.
- Sits between the row 1-D DCT output and the column 1-D DCT input; drives the buffer's write and read ports directly.

---
 rtl/dct_transpose_ctrl_pkg.sv | 24 ++
 rtl/dct_skid_fifo.sv | 59 +++++
 rtl/dct_transpose_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dct_transpose_ctrl_pkg.sv
// Shared constants and address helper for the DCT transpose buffer controller.
// Buffer address layout: addr[7]=0, addr[6]=bank, addr[5:3]=row, addr[2:0]=col.
package dct_transpose_ctrl_pkg;

   localparam int unsigned BLK_SIZE = 64;  // coefficients per 8x8 block
   localparam int unsigned DIM      = 8;   // block edge length
   localparam int unsigned ADDR_W   = 8;   // buffer address width
   localparam int unsigned BANK_BIT = 6;   // ping-pong bank select bit in the address

   localparam logic [2:0] LAST_IDX = 3'(DIM - 1);

   // Pack {bank,row,col} into a buffer address; the top address bit is always 0.
   function automatic logic [ADDR_W-1:0] pack_addr(input logic       bank,
                                                   input logic [2:0] row,
                                                   input logic [2:0] col);
      logic [ADDR_W-1:0] addr;
      addr           = '0;
      addr[BANK_BIT] = bank;
      addr[5:3]      = row;
      addr[2:0]      = col;
      return addr;
   endfunction

endpackage

// File: rtl/dct_skid_fifo.sv
// Two-entry registered FIFO used as the output skid of the transpose controller.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   push, wdata    write strobe and data (ignored when full unless popping)
//   pop            read strobe (ignored when empty)
//   rdata          head entry, straight from the storage registers
//   count          number of stored entries (0..2)
//   empty, full    occupancy flags
module dct_skid_fifo #(
   parameter int unsigned WIDTH = 14
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [1:0]       count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [2];
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_q <= ~wr_ptr_q;
         if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only observed while count is non-zero.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == 2'd0);
   assign full  = (count_q == 2'd2);

endmodule

// File: rtl/dct_transpose_ctrl.sv
// Sequencer for the ping-pong DCT transpose buffer. Row-pass coefficients are written
// row-major into one 64-entry bank while the other full bank is read back column-major
// into a 2-entry output skid, giving the transposed block on a valid/ready stream.
// Ports:
//   clock, reset                     system clock, synchronous active-high reset
//   in_valid, in_ready, in_data      row-pass coefficient stream (row-major)
//   out_valid, out_ready, out_data   transposed coefficient stream (column-major)
//   out_last                         marks the 64th coefficient of a block
//   ram_we, ram_waddr, ram_wdata     buffer write port
//   ram_raddr, ram_rdata             buffer read port (data one cycle after address)
//   bank_full                        per-bank full flags
module dct_transpose_ctrl
   import dct_transpose_ctrl_pkg::*;
#(
   parameter int unsigned D_WIDTH    = 13,
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [D_WIDTH-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [D_WIDTH-1:0] out_data,
   output logic               out_last,
   output logic               ram_we,
   output logic [ADDR_W-1:0]  ram_waddr,
   output logic [D_WIDTH-1:0] ram_wdata,
   output logic [ADDR_W-1:0]  ram_raddr,
   input  logic [D_WIDTH-1:0] ram_rdata,
   output logic [1:0]         bank_full
);

   logic             wbank_q;
   logic [2:0]       wrow_q;
   logic [2:0]       wcol_q;
   logic             rbank_q;
   logic [2:0]       rrow_q;
   logic [2:0]       rcol_q;
   logic [1:0]       bank_full_q;
   logic [1:0]       bank_full_d;
   logic             inflight_q;
   logic             inflight_last_q;

   logic             accept;
   logic             wr_done;
   logic             issue;
   logic             rd_done;
   logic             pop;
   logic [2:0]       occupancy;
   logic [1:0]       skid_count;
   logic             skid_empty;
   logic             skid_full;
   logic [D_WIDTH:0] skid_head;

   // Write side
   assign in_ready  = !reset && !bank_full_q[wbank_q];
   assign accept    = in_valid && in_ready;
   assign wr_done   = accept && (wrow_q == LAST_IDX) && (wcol_q == LAST_IDX);
   assign ram_we    = accept;
   assign ram_waddr = pack_addr(wbank_q, wrow_q, wcol_q);
   assign ram_wdata = in_data;

   // Read side. A pop in the current cycle frees a skid slot before the word issued
   // now lands, so it is credited here; without it the stream would run at half rate.
   assign pop       = out_valid && out_ready;
   assign occupancy = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = !reset && bank_full_q[rbank_q] && (occupancy < 3'(SKID_DEPTH))
                      && !(skid_full && !pop);
   assign rd_done   = issue && (rrow_q == LAST_IDX) && (rcol_q == LAST_IDX);
   assign ram_raddr = pack_addr(rbank_q, rrow_q, rcol_q);

   // Set and clear always target different banks, so both may apply in one cycle.
   always_comb begin
      bank_full_d = bank_full_q;
      if (wr_done) bank_full_d[wbank_q] = 1'b1;
      if (rd_done) bank_full_d[rbank_q] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wbank_q         <= 1'b0;
         wrow_q          <= 3'd0;
         wcol_q          <= 3'd0;
         rbank_q         <= 1'b0;
         rrow_q          <= 3'd0;
         rcol_q          <= 3'd0;
         bank_full_q     <= 2'b00;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         if (accept) begin
            // Row-major: column is the inner counter
            wcol_q <= wcol_q + 3'd1;
            if (wcol_q == LAST_IDX) wrow_q <= wrow_q + 3'd1;
            if (wr_done) wbank_q <= ~wbank_q;
         end
         if (issue) begin
            // Column-major: row is the inner counter
            rrow_q <= rrow_q + 3'd1;
            if (rrow_q == LAST_IDX) rcol_q <= rcol_q + 3'd1;
            if (rd_done) rbank_q <= ~rbank_q;
         end
         bank_full_q     <= bank_full_d;
         inflight_q      <= issue;
         inflight_last_q <= rd_done;
      end
   end

   dct_skid_fifo #(
      .WIDTH (D_WIDTH + 1)
   ) u_skid (
      .clock (clock),
      .reset (reset),
      .push  (inflight_q),
      .wdata ({inflight_last_q, ram_rdata}),
      .pop   (pop),
      .rdata (skid_head),
      .count (skid_count),
      .empty (skid_empty),
      .full  (skid_full)
   );

   assign out_valid = !skid_empty;
   assign out_data  = skid_head[D_WIDTH-1:0];
   assign out_last  = out_valid && skid_head[D_WIDTH];
   assign bank_full = bank_full_q;

endmodule
